// File: rtl/fdga_pkg.sv
// Shared types and constants for the writeback path into the register file.
package fdga_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

  // Index width that stays legal for a single-entry arbiter.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1, grants the first set request,
// and moves the pointer to the winner only when the grant is consumed.
module rr_arbiter
  import fdga_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Pointer starts at the last index so requester 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IDX_W'(N - 1);
    end else if (advance && (|grant)) begin
      r_ptr <= grant_idx;
    end
  end

  // One extra bit in w_sum covers ptr+k up to 2N-1 before the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W + 1)'(k);
      if (w_sum >= (IDX_W + 1)'(N)) begin
        w_sum = w_sum - (IDX_W + 1)'(N);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!w_found && req[w_cand]) begin
        grant[w_cand] = 1'b1;
        grant_idx     = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources and
// registers the winning write onto WE3/AD3/WD3.
module regfile_wb_arbiter
  import fdga_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int GID_W   = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  output logic                      wb_pending_valid,
  output logic [ADDR_W-1:0]         wb_pending_addr,
  output logic [GID_W-1:0]          grant_id
);

  logic [NUM_REQ-1:0] w_grant;
  logic [GID_W-1:0]   w_gidx;
  logic               w_hs;
  logic [ADDR_W-1:0]  w_gaddr;
  logic [DATA_W-1:0]  w_gdata;
  logic               w_gnonzero;

  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic [GID_W-1:0]   r_gid;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (GID_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (w_hs),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  // The register file never stalls, so any visible ready is a handshake.
  assign req_ready = rst ? '0 : w_grant;
  assign w_hs      = |req_ready;

  assign w_gaddr    = req_addr[w_gidx*ADDR_W +: ADDR_W];
  assign w_gdata    = req_data[w_gidx*DATA_W +: DATA_W];
  assign w_gnonzero = (w_gaddr != ADDR_W'(REG_ZERO));

  // x0 writes are consumed but never raise WE3.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_gid  <= '0;
    end else begin
      r_we <= w_hs && w_gnonzero;
      if (w_hs) begin
        r_addr <= w_gaddr;
        r_data <= w_gdata;
        r_gid  <= w_gidx;
      end
    end
  end

  assign rf_we            = r_we;
  assign rf_addr          = r_addr;
  assign rf_data          = r_data;
  assign grant_id         = r_gid;
  assign wb_pending_valid = r_we;
  assign wb_pending_addr  = r_addr;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a negedge-capturing register file model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        wb_pending_valid;
  logic [4:0]  wb_pending_addr;
  logic [1:0]  grant_id;

  logic [31:0] regs [32];
  logic        clr_mem;

  int checks;
  int failures;

  regfile_wb_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .rf_we            (rf_we),
    .rf_addr          (rf_addr),
    .rf_data          (rf_data),
    .wb_pending_valid (wb_pending_valid),
    .wb_pending_addr  (wb_pending_addr),
    .grant_id         (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: captures on negedge, no x0 filtering so stray x0 writes show.
  always @(negedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (rf_we) begin
      regs[rf_addr] <= rf_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]         = v;
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL rst_ready got=%b exp=000", req_ready); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", rf_we); end
      checks++; if (rf_addr !== 5'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", rf_addr); end
      checks++; if (rf_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", rf_data); end
    end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_gid got=%0d exp=0", grant_id); end
    checks++; if (wb_pending_valid !== 1'b0) begin failures++; $display("FAIL rst_pend got=%b exp=0", wb_pending_valid); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL rst_first_grant got=%b exp=001", req_ready); end
    req_valid = 3'b000;
  endtask

  task automatic test_single;
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    tick();
    req_valid = 3'b000;
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL single_we got=%b exp=1", rf_we); end
    checks++; if (rf_addr !== 5'd5) begin failures++; $display("FAIL single_addr got=%0d exp=5", rf_addr); end
    checks++; if (rf_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", rf_data); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL single_gid got=%0d exp=0", grant_id); end
    checks++; if (wb_pending_valid !== 1'b1 || wb_pending_addr !== 5'd5) begin failures++; $display("FAIL single_pend got=%b/%0d exp=1/5", wb_pending_valid, wb_pending_addr); end
    @(negedge clk);
    #1;
    checks++; if (regs[5] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_read_x5 got=%h exp=deadbeef", regs[5]); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL single_idle_we got=%b exp=0", rf_we); end
    checks++; if (rf_addr !== 5'd5 || rf_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold got=%0d/%h exp=5/deadbeef", rf_addr, rf_data); end
  endtask

  task automatic test_fairness;
    logic [1:0] ord [6];
    logic [2:0] exp_rdy;
    int cnt [3];
    ord = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    cnt = '{0, 0, 0};
    pulse_reset();
    set_req(0, 1'b1, 5'd1, 32'h100);
    set_req(1, 1'b1, 5'd2, 32'h101);
    set_req(2, 1'b1, 5'd3, 32'h102);
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_rdy = 3'b001 << ord[c];
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL fair_ready[%0d] got=%b exp=%b", c, req_ready, exp_rdy); end
      tick();
      checks++; if (grant_id !== ord[c] || rf_we !== 1'b1) begin failures++; $display("FAIL fair_gid[%0d] got=%0d/%b exp=%0d/1", c, grant_id, rf_we, ord[c]); end
      checks++; if (rf_data !== 32'h100 + 32'(ord[c])) begin failures++; $display("FAIL fair_data[%0d] got=%h exp=%h", c, rf_data, 32'h100 + 32'(ord[c])); end
      if (grant_id <= 2'd2) cnt[grant_id]++;
    end
    req_valid = 3'b000;
    for (int r = 0; r < 3; r++) begin
      checks++; if (cnt[r] != 2) begin failures++; $display("FAIL fair_count[%0d] got=%0d exp=2", r, cnt[r]); end
    end
  endtask

  task automatic test_x0;
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL x0_ready got=%b exp=010", req_ready); end
    tick();
    checks++; if (rf_we !== 1'b0 || wb_pending_valid !== 1'b0) begin failures++; $display("FAIL x0_we got=%b/%b exp=0/0", rf_we, wb_pending_valid); end
    checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL x0_gid got=%0d exp=1", grant_id); end
    set_req(0, 1'b1, 5'd4, 32'h40);
    set_req(1, 1'b1, 5'd4, 32'h41);
    set_req(2, 1'b1, 5'd4, 32'h42);
    #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL x0_ptr_adv got=%b exp=100", req_ready); end
    req_valid = 3'b000;
    @(negedge clk);
    #1;
    checks++; if (regs[0] !== 32'h0) begin failures++; $display("FAIL x0_read got=%h exp=0", regs[0]); end
  endtask

  task automatic test_collision;
    pulse_reset();
    set_req(0, 1'b1, 5'd7, 32'hAAAA0000);
    set_req(2, 1'b1, 5'd7, 32'hBBBB2222);
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL coll_ready0 got=%b exp=001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    checks++; if (rf_data !== 32'hAAAA0000 || grant_id !== 2'd0) begin failures++; $display("FAIL coll_first got=%h/%0d exp=aaaa0000/0", rf_data, grant_id); end
    #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL coll_ready2 got=%b exp=100", req_ready); end
    tick();
    req_valid = 3'b000;
    checks++; if (rf_data !== 32'hBBBB2222 || grant_id !== 2'd2 || rf_addr !== 5'd7) begin failures++; $display("FAIL coll_second got=%h/%0d/%0d exp=bbbb2222/2/7", rf_data, grant_id, rf_addr); end
    @(negedge clk);
    #1;
    checks++; if (regs[7] !== 32'hBBBB2222) begin failures++; $display("FAIL coll_read_x7 got=%h exp=bbbb2222", regs[7]); end
  endtask

  task automatic test_reset_mid;
    set_req(1, 1'b1, 5'd9, 32'h5555);
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL midrst_ready got=%b exp=010", req_ready); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL midrst_ready_forced got=%b exp=000", req_ready); end
    tick();
    req_valid = 3'b000;
    rst = 1'b0;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL midrst_we got=%b exp=0", rf_we); end
    @(negedge clk);
    #1;
    checks++; if (regs[9] !== 32'h0) begin failures++; $display("FAIL midrst_read_x9 got=%h exp=0", regs[9]); end
    set_req(1, 1'b1, 5'd10, 32'h7777);
    tick();
    req_valid = 3'b000;
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd10) begin failures++; $display("FAIL inflight_we got=%b/%0d exp=1/10", rf_we, rf_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'h0 || grant_id !== 2'd0) begin failures++; $display("FAIL inflight_drop got=%b/%0d/%h/%0d exp=0/0/0/0", rf_we, rf_addr, rf_data, grant_id); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    clr_mem   = 1'b1;
    req_valid = 3'b000;
    req_addr  = '0;
    req_data  = '0;
    @(negedge clk);
    #1;
    clr_mem = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_x0();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
